// File: rtl/mux_sel_pipe_pkg.sv
// Shared constants, select-mode encodings and pipeline states for the registered N:1 vector selector.
package mux_sel_pipe_pkg;

  localparam int LANE8  = 8;
  localparam int LANE16 = 16;
  localparam int LANE32 = 32;
  localparam int LANE64 = 64;

  typedef enum logic {
    MODE_BCAST = 1'b0,
    MODE_LANE  = 1'b1
  } sel_mode_e;

  // EMPTY: nothing held; ONE: main register full; TWO: main and skid full.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  function automatic int num_lanes(input int w, input int lane_w);
    return w / lane_w;
  endfunction

endpackage

// File: rtl/mux_sel_pipe_if.sv
// Handshake and data bundle of mux_sel_pipe; master is the producer/consumer side, slave is the selector.
interface mux_sel_pipe_if
  import mux_sel_pipe_pkg::*;
#(
  parameter int W      = 128,
  parameter int NUM_IN = 2,
  parameter int LANE_W = 32,
  parameter int SEL_W  = 3
);
  localparam int NUM_LANES = num_lanes(W, LANE_W);

  logic                       in_valid;
  logic                       in_ready;
  logic [NUM_IN*W-1:0]        in_data;
  logic [NUM_LANES*SEL_W-1:0] in_sel;
  logic                       in_lane_mode;
  logic                       out_valid;
  logic                       out_ready;
  logic [W-1:0]               out_data;
  logic                       out_err;

  modport master (
    output in_valid, in_data, in_sel, in_lane_mode, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_data, in_sel, in_lane_mode, out_ready,
    output in_ready, out_valid, out_data, out_err
  );

endinterface

// File: rtl/mux_sel_pipe_lane.sv
// Combinational N:1 select of one lane; out-of-range selects give all zeros and raise err.
module mux_lane_sel #(
  parameter int NUM_IN = 2,
  parameter int LANE_W = 32,
  parameter int SEL_W  = 3
) (
  input  logic [NUM_IN*LANE_W-1:0] src,
  input  logic [SEL_W-1:0]         sel,
  output logic [LANE_W-1:0]        lane,
  output logic                     err
);

  always_comb begin
    lane = '0;
    err  = 1'b1;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        lane = src[k*LANE_W +: LANE_W];
        err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_sel_pipe.sv
// Registered N:1 vector/lane selector with valid/ready and a 2-entry skid; 1-cycle latency,
// in_ready comes from registers only (never from out_ready) and drops while the skid is full.
module mux_sel_pipe
  import mux_sel_pipe_pkg::*;
#(
  parameter int W      = 128,
  parameter int NUM_IN = 2,
  parameter int LANE_W = 32,
  parameter int SEL_W  = 3
) (
  input  logic          clk,
  input  logic          rst,
  mux_sel_pipe_if.slave bus
);

  localparam int NUM_LANES = num_lanes(W, LANE_W);

  logic [W-1:0]         res_data;
  logic [NUM_LANES-1:0] lane_err;
  logic                 res_err;
  logic [SEL_W-1:0]     sel_bcast;

  // Bit 0 of every field is its leftmost (MSB) bit, so input 0, lane 0 and the
  // lane-0 select all sit at the top of their packed vectors.
  assign sel_bcast = bus.in_sel[(NUM_LANES-1)*SEL_W +: SEL_W];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam int P = NUM_LANES - 1 - i;
    logic [NUM_IN*LANE_W-1:0] srcs;
    logic [SEL_W-1:0]         sel;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_src
      assign srcs[k*LANE_W +: LANE_W] = bus.in_data[(NUM_IN-1-k)*W + P*LANE_W +: LANE_W];
    end

    assign sel = (sel_mode_e'(bus.in_lane_mode) == MODE_LANE) ?
                 bus.in_sel[P*SEL_W +: SEL_W] : sel_bcast;

    mux_lane_sel #(
      .NUM_IN (NUM_IN),
      .LANE_W (LANE_W),
      .SEL_W  (SEL_W)
    ) u_lane_sel (
      .src  (srcs),
      .sel  (sel),
      .lane (res_data[P*LANE_W +: LANE_W]),
      .err  (lane_err[i])
    );
  end

  assign res_err = |lane_err;

  state_e       state_q, state_d;
  logic [W-1:0] data_q, data_d;
  logic         err_q, err_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         skid_err_q, skid_err_d;
  logic         accept, handoff;

  assign bus.in_ready  = (state_q != ST_TWO) && !rst;
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign bus.out_data  = data_q;
  assign bus.out_err   = err_q;

  assign accept  = bus.in_valid && bus.in_ready;
  assign handoff = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    err_d       = err_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          data_d  = res_data;
          err_d   = res_err;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && handoff) begin
          data_d = res_data;
          err_d  = res_err;
        end else if (accept) begin
          skid_data_d = res_data;
          skid_err_d  = res_err;
          state_d     = ST_TWO;
        end else if (handoff) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (handoff) begin
          data_d      = skid_data_q;
          err_d       = skid_err_q;
          skid_data_d = '0;
          skid_err_d  = 1'b0;
          state_d     = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      data_q      <= '0;
      err_q       <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      err_q       <= err_d;
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
    end
  end

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Bench for mux_sel_pipe: lane-select vector table on NUM_IN=4/3 instances, scoreboarded
// handshake sequences (latency, back-pressure, throughput, reset in TWO) on the default instance.
module tb_mux_sel_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_sel_pipe_if #(.NUM_IN(2)) ifa();
  mux_sel_pipe_if #(.NUM_IN(4)) ifb();
  mux_sel_pipe_if #(.NUM_IN(3)) ifc();

  mux_sel_pipe #(.NUM_IN(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  mux_sel_pipe #(.NUM_IN(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  mux_sel_pipe #(.NUM_IN(3)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  typedef struct {
    logic [127:0] data;
    logic         err;
  } exp_t;

  typedef struct {
    logic         mode;
    logic [11:0]  sel;
    logic [127:0] exp_b;
    logic         err_b;
    logic [127:0] exp_c;
    logic         err_c;
  } vec_t;

  localparam logic [127:0] L0 = {32{4'h0}};
  localparam logic [127:0] L1 = {32{4'h1}};
  localparam logic [127:0] L2 = {32{4'h2}};
  localparam logic [127:0] L3 = {32{4'h3}};

  int   errs = 0;
  int   checks = 0;
  int   out_cnt = 0;
  exp_t sbq[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference for the 2-input instance: input 0 is the upper 128 bits, lane 0 is the top lane.
  function automatic exp_t model_a(input logic [255:0] d, input logic [11:0] sel, input logic mode);
    exp_t       e;
    logic [2:0] s;
    e.data = '0;
    e.err  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = mode ? sel[(3-i)*3 +: 3] : sel[11:9];
      if (s == 3'd0)      e.data[(3-i)*32 +: 32] = d[128 + (3-i)*32 +: 32];
      else if (s == 3'd1) e.data[(3-i)*32 +: 32] = d[(3-i)*32 +: 32];
      else                e.err = 1'b1;
    end
    return e;
  endfunction

  // Scoreboard on instance A: push on accept, pop and compare on handoff.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
    end else begin
      if (ifa.out_valid && ifa.out_ready) begin
        out_cnt++;
        if (sbq.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL sb_spurious: got out_data=%h, required no output", ifa.out_data);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("sb_data", ifa.out_data, e.data);
          check("sb_err", {127'b0, ifa.out_err}, {127'b0, e.err});
        end
      end
      if (ifa.in_valid && ifa.in_ready)
        sbq.push_back(model_a(ifa.in_data, ifa.in_sel, ifa.in_lane_mode));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [255:0] d, input logic [11:0] sel, input logic mode);
    ifa.in_data      = d;
    ifa.in_sel       = sel;
    ifa.in_lane_mode = mode;
    ifa.in_valid     = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[7];
    int   c0;
    int   drops;
    int   gaps;
    bit   got;

    vecs[0] = '{1'b1, {3'd3, 3'd2, 3'd1, 3'd0}, 128'h33333333_22222222_11111111_00000000, 1'b0,
                128'h00000000_22222222_11111111_00000000, 1'b1};
    vecs[1] = '{1'b1, {3'd0, 3'd1, 3'd7, 3'd2}, 128'h00000000_11111111_00000000_22222222, 1'b1,
                128'h00000000_11111111_00000000_22222222, 1'b1};
    vecs[2] = '{1'b1, {3'd0, 3'd1, 3'd2, 3'd0}, 128'h00000000_11111111_22222222_00000000, 1'b0,
                128'h00000000_11111111_22222222_00000000, 1'b0};
    vecs[3] = '{1'b0, {3'd2, 3'd7, 3'd7, 3'd7}, L2, 1'b0, L2, 1'b0};
    vecs[4] = '{1'b0, {3'd3, 3'd0, 3'd0, 3'd0}, L3, 1'b0, L0, 1'b1};
    vecs[5] = '{1'b1, {3'd1, 3'd3, 3'd4, 3'd2}, 128'h11111111_33333333_00000000_22222222, 1'b1,
                128'h11111111_00000000_00000000_22222222, 1'b1};
    vecs[6] = '{1'b0, {3'd4, 3'd1, 3'd1, 3'd1}, L0, 1'b1, L0, 1'b1};

    rst = 1'b1;
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.in_sel = '0; ifa.in_lane_mode = 1'b0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.in_data = {L0, L1, L2, L3}; ifb.in_sel = '0; ifb.in_lane_mode = 1'b0;
    ifb.out_ready = 1'b1;
    ifc.in_valid = 1'b0; ifc.in_data = {L0, L1, L2}; ifc.in_sel = '0; ifc.in_lane_mode = 1'b0;
    ifc.out_ready = 1'b1;

    // Reset state
    repeat (2) step();
    @(negedge clk);
    check("rst_in_ready", {127'b0, ifa.in_ready}, 128'd0);
    check("rst_out_valid", {127'b0, ifa.out_valid}, 128'd0);
    check("rst_out_data", ifa.out_data, 128'd0);
    check("rst_out_err", {127'b0, ifa.out_err}, 128'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", {127'b0, ifa.in_ready}, 128'd1);

    // Lane-select vector table on the 4-input and 3-input instances
    for (int v = 0; v < 7; v++) begin
      step();
      ifb.in_sel = vecs[v].sel; ifb.in_lane_mode = vecs[v].mode; ifb.in_valid = 1'b1;
      ifc.in_sel = vecs[v].sel; ifc.in_lane_mode = vecs[v].mode; ifc.in_valid = 1'b1;
      step();
      ifb.in_valid = 1'b0;
      ifc.in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_b_valid", v), {127'b0, ifb.out_valid}, 128'd1);
      check($sformatf("vec%0d_b_data", v), ifb.out_data, vecs[v].exp_b);
      check($sformatf("vec%0d_b_err", v), {127'b0, ifb.out_err}, {127'b0, vecs[v].err_b});
      check($sformatf("vec%0d_c_data", v), ifc.out_data, vecs[v].exp_c);
      check($sformatf("vec%0d_c_err", v), {127'b0, ifc.out_err}, {127'b0, vecs[v].err_c});
    end

    // Default 2:1 broadcast: latency, in-range and out-of-range selects
    step();
    ifa.out_ready = 1'b1;
    drive_a({128'h0, L1}, {3'd0, 9'd0}, 1'b0);
    step();
    drive_a({128'h0, L1}, {3'd1, 9'd0}, 1'b0);
    @(negedge clk);
    check("lat_valid", {127'b0, ifa.out_valid}, 128'd1);
    check("lat_data", ifa.out_data, 128'h0);
    step();
    drive_a({128'h0, L1}, {3'd2, 9'd0}, 1'b0);
    step();
    drive_a({{32{4'hA}}, {32{4'h5}}}, {3'd1, 9'd0}, 1'b0);
    step();
    ifa.in_valid = 1'b0;
    repeat (2) step();

    // Back-pressure: A in main, B in skid, C refused until the consumer drains
    ifa.out_ready = 1'b0;
    drive_a({128'hA0A0_0001, 128'h0}, 12'd0, 1'b0);
    step();
    drive_a({128'hB0B0_0002, 128'h0}, 12'd0, 1'b0);
    step();
    drive_a({128'hC0C0_0003, 128'h0}, 12'd0, 1'b0);
    @(negedge clk);
    check("bp_in_ready", {127'b0, ifa.in_ready}, 128'd0);
    check("bp_main", ifa.out_data, 128'hA0A0_0001);
    step();
    @(negedge clk);
    check("bp_hold_valid", {127'b0, ifa.out_valid}, 128'd1);
    check("bp_hold_data", ifa.out_data, 128'hA0A0_0001);
    c0 = out_cnt;
    step();
    ifa.out_ready = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (ifa.in_ready) begin
        got = 1'b1;
        break;
      end
    end
    check("bp_c_accept", {127'b0, got}, 128'd1);
    step();
    ifa.in_valid = 1'b0;
    repeat (4) step();
    check("bp_count", 128'(out_cnt - c0), 128'd3);

    // Full throughput: 16 back-to-back transactions
    c0 = out_cnt;
    drops = 0;
    gaps = 0;
    for (int i = 0; i < 16; i++) begin
      drive_a({128'(i + 1), 128'h0}, 12'd0, 1'b0);
      @(negedge clk);
      if (!ifa.in_ready) drops++;
      if (i > 0 && !ifa.out_valid) gaps++;
      step();
    end
    ifa.in_valid = 1'b0;
    @(negedge clk);
    if (!ifa.out_valid) gaps++;
    repeat (2) step();
    check("tp_ready_drops", 128'(drops), 128'd0);
    check("tp_valid_gaps", 128'(gaps), 128'd0);
    check("tp_count", 128'(out_cnt - c0), 128'd16);

    // Reset while TWO: nothing held may ever emerge
    ifa.out_ready = 1'b0;
    drive_a({128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 128'h0}, {3'd0, 3'd5, 3'd0, 3'd0}, 1'b1);
    step();
    drive_a({128'h0, {32{4'h5}}}, {3'd1, 9'd0}, 1'b0);
    step();
    @(negedge clk);
    check("two_in_ready", {127'b0, ifa.in_ready}, 128'd0);
    check("two_main", ifa.out_data, 128'hDEADBEEF_00000000_01234567_89ABCDEF);
    check("two_err", {127'b0, ifa.out_err}, 128'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ifa.in_valid = 1'b0;
    @(negedge clk);
    check("rst2_out_valid", {127'b0, ifa.out_valid}, 128'd0);
    check("rst2_out_data", ifa.out_data, 128'd0);
    check("rst2_out_err", {127'b0, ifa.out_err}, 128'd0);
    check("rst2_in_ready", {127'b0, ifa.in_ready}, 128'd1);
    c0 = out_cnt;
    ifa.out_ready = 1'b1;
    repeat (5) step();
    drive_a({128'hFEED_0000_0000_0042, 128'h0}, 12'd0, 1'b0);
    step();
    ifa.in_valid = 1'b0;
    repeat (3) step();
    check("rst2_count", 128'(out_cnt - c0), 128'd1);
    check("sb_drain", 128'(sbq.size()), 128'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
